// File: rtl/fifo_wr_stream_arbiter_if.sv
// Stream-source and FIFO write-port bundle for the write-side packet arbiter.
interface fifo_wr_stream_arbiter_if #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 2
);
    logic [NUM_SRC*DATA_WIDTH-1:0]    s_tdata;
    logic [NUM_SRC-1:0]               s_tvalid;
    logic [NUM_SRC-1:0]               s_tlast;
    logic [NUM_SRC-1:0]               s_tready;
    logic [DATA_WIDTH+ID_WIDTH:0]     fifo_din;
    logic                             fifo_wr_en;
    logic                             fifo_full;

    modport master (
        output s_tdata, s_tvalid, s_tlast, fifo_full,
        input  s_tready, fifo_din, fifo_wr_en
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tlast, fifo_full,
        output s_tready, fifo_din, fifo_wr_en
    );
endinterface

// File: rtl/fifo_wr_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the async FIFO write port among stream sources.
// FIFO words are {last, src_id, data}; a grant is held from the first beat up to last.
module fifo_wr_stream_arbiter #(
    parameter int unsigned NUM_SRC       = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ID_WIDTH      = 2,
    parameter int unsigned MAX_PKT_BEATS = 256
) (
    input  logic                    wr_clk,
    input  logic                    wr_rst,
    fifo_wr_stream_arbiter_if.slave bus,
    output logic [ID_WIDTH-1:0]     grant_id,
    output logic                    busy,
    output logic [15:0]             pkt_count,
    output logic [7:0]              trunc_count
);
    localparam int unsigned BEAT_W = $clog2(MAX_PKT_BEATS) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_d;
    logic [ID_WIDTH-1:0]     grant_d;
    logic [BEAT_W-1:0]       beat_cnt, beat_d;
    logic [15:0]             pkt_d;
    logic [7:0]              trunc_d;

    logic                    req_found;
    logic [ID_WIDTH-1:0]     req_id;
    int unsigned             hop, best_hop;

    logic [DATA_WIDTH-1:0]   src_data;
    logic                    src_valid, src_last;
    logic                    xfer, last_out;

    // Select the granted source's beat
    always_comb begin
        src_data  = '0;
        src_valid = 1'b0;
        src_last  = 1'b0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            if (grant_id == ID_WIDTH'(j)) begin
                src_data  = bus.s_tdata[j*DATA_WIDTH +: DATA_WIDTH];
                src_valid = bus.s_tvalid[j];
                src_last  = bus.s_tlast[j];
            end
        end
    end

    // Round-robin search: hop 0 is the source right after the last grant
    always_comb begin
        req_found = 1'b0;
        req_id    = grant_id;
        best_hop  = NUM_SRC;
        hop       = 0;
        for (int unsigned j = 0; j < NUM_SRC; j++) begin
            hop = (j + NUM_SRC - 1 - 32'(grant_id)) % NUM_SRC;
            if (bus.s_tvalid[j] && (hop < best_hop)) begin
                best_hop  = hop;
                req_id    = ID_WIDTH'(j);
                req_found = 1'b1;
            end
        end
    end

    assign busy     = (state == BUSY);
    assign xfer     = busy && src_valid && !bus.fifo_full;
    assign last_out = src_last || (beat_cnt == BEAT_W'(MAX_PKT_BEATS - 1));

    assign bus.fifo_wr_en = xfer;
    assign bus.s_tready   = (busy && !bus.fifo_full) ? (NUM_SRC'(1) << grant_id) : '0;
    assign bus.fifo_din   = busy ? {last_out, grant_id, src_data} : '0;

    // Next state, grant and counters
    always_comb begin
        state_d = state;
        grant_d = grant_id;
        beat_d  = beat_cnt;
        pkt_d   = pkt_count;
        trunc_d = trunc_count;
        case (state)
            IDLE: begin
                if (req_found) begin
                    state_d = BUSY;
                    grant_d = req_id;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (last_out) begin
                        state_d = IDLE;
                        beat_d  = '0;
                        pkt_d   = pkt_count + 16'd1;
                        if (!src_last && (trunc_count != 8'hFF)) begin
                            trunc_d = trunc_count + 8'd1;
                        end
                    end else begin
                        beat_d = beat_cnt + BEAT_W'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state       <= IDLE;
            grant_id    <= ID_WIDTH'(NUM_SRC - 1);
            beat_cnt    <= '0;
            pkt_count   <= '0;
            trunc_count <= '0;
        end else begin
            state       <= state_d;
            grant_id    <= grant_d;
            beat_cnt    <= beat_d;
            pkt_count   <= pkt_d;
            trunc_count <= trunc_d;
        end
    end
endmodule

// File: tb/tb_fifo_wr_stream_arbiter.sv
// Randomized scoreboard bench for the write-side packet arbiter against a packet-level model.
module tb_fifo_wr_stream_arbiter;
    localparam int unsigned NUM_SRC       = 4;
    localparam int unsigned DATA_WIDTH    = 32;
    localparam int unsigned ID_WIDTH      = 2;
    localparam int unsigned MAX_PKT_BEATS = 4;
    localparam int unsigned WORD_W        = DATA_WIDTH + ID_WIDTH + 1;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    logic wr_clk = 1'b0;
    logic wr_rst = 1'b0;
    always #5 wr_clk = ~wr_clk;

    fifo_wr_stream_arbiter_if #(
        .NUM_SRC(NUM_SRC), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) bus ();

    logic [ID_WIDTH-1:0] grant_id;
    logic                busy;
    logic [15:0]         pkt_count;
    logic [7:0]          trunc_count;

    fifo_wr_stream_arbiter #(
        .NUM_SRC(NUM_SRC), .DATA_WIDTH(DATA_WIDTH),
        .ID_WIDTH(ID_WIDTH), .MAX_PKT_BEATS(MAX_PKT_BEATS)
    ) dut (
        .wr_clk(wr_clk),
        .wr_rst(wr_rst),
        .bus(bus.slave),
        .grant_id(grant_id),
        .busy(busy),
        .pkt_count(pkt_count),
        .trunc_count(trunc_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Pending beats per source and expected FIFO words in write order
    beat_t             src_q [NUM_SRC][$];
    logic [WORD_W-1:0] exp_q [$];
    logic [WORD_W-1:0] mon_word;

    // Packet-level model: in a packet or not, which source, beats so far
    bit          m_busy  = 0;
    int unsigned m_src   = NUM_SRC - 1;
    int unsigned m_beats = 0;
    int unsigned m_pkts  = 0;
    int unsigned m_trunc = 0;

    bit                  mon_en    = 0;
    bit                  exp_wr    = 0;
    bit                  exp_busy  = 0;
    logic [NUM_SRC-1:0]  exp_ready = '0;
    logic [ID_WIDTH-1:0] exp_gid   = '0;

    int          full_mode  = 0;
    int          stall_left = 0;
    bit          gaps       = 0;
    int unsigned obs_cnt [NUM_SRC];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic bit pending();
        for (int s = 0; s < NUM_SRC; s++) if (src_q[s].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic add_pkt(int unsigned s, int unsigned len);
        beat_t b;
        for (int unsigned i = 0; i < len; i++) begin
            b.data = $urandom;
            b.last = (i == len - 1);
            src_q[s].push_back(b);
        end
    endtask

    // Drive one cycle of source/FIFO inputs and advance the model over that cycle
    task automatic drive_and_model();
        logic [NUM_SRC-1:0]            v;
        logic [NUM_SRC-1:0]            l;
        logic [NUM_SRC*DATA_WIDTH-1:0] d;
        bit                            full;
        bit                            lo;
        beat_t                         b;
        v = '0;
        l = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            d[s*DATA_WIDTH +: DATA_WIDTH] = $urandom;
            if (src_q[s].size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
                v[s] = 1'b1;
                l[s] = src_q[s][0].last;
                d[s*DATA_WIDTH +: DATA_WIDTH] = src_q[s][0].data;
            end
        end
        case (full_mode)
            0:       full = 1'b0;
            1:       full = ($urandom_range(3) == 0);
            default: begin
                full = m_busy && (m_beats == 2) && (stall_left > 0);
                if (full) stall_left--;
            end
        endcase
        bus.s_tvalid  = v;
        bus.s_tlast   = l;
        bus.s_tdata   = d;
        bus.fifo_full = full;

        exp_busy  = m_busy;
        exp_gid   = ID_WIDTH'(m_src);
        exp_wr    = 1'b0;
        exp_ready = '0;
        if (m_busy) begin
            if (!full) exp_ready[m_src] = 1'b1;
            if (v[m_src] && !full) begin
                b = src_q[m_src].pop_front();
                m_beats++;
                lo = b.last || (m_beats == MAX_PKT_BEATS);
                exp_wr = 1'b1;
                exp_q.push_back({lo, ID_WIDTH'(m_src), b.data});
                if (lo) begin
                    m_busy  = 0;
                    m_beats = 0;
                    m_pkts++;
                    if (!b.last && m_trunc < 255) m_trunc++;
                end
            end
        end else begin
            for (int unsigned k = 1; k <= NUM_SRC; k++) begin
                if (v[(m_src + k) % NUM_SRC]) begin
                    m_src  = (m_src + k) % NUM_SRC;
                    m_busy = 1;
                    break;
                end
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) begin
            drive_and_model();
            mon_en = 1;
            @(posedge wr_clk);
            #1;
        end
    endtask

    task automatic drain();
        int budget;
        budget = 3000;
        while ((m_busy || pending()) && budget > 0) begin
            run(1);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: packets still pending at %0t", $time);
        end
        run(2);
        check("pkt_count", 64'(pkt_count), 64'(m_pkts & 32'hFFFF));
        check("trunc_count", 64'(trunc_count), 64'(m_trunc));
        check("exp_queue_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Async reset at the current instant; outputs must clear without a clock edge
    task automatic do_reset();
        wr_rst = 1'b1;
        mon_en = 0;
        #1;
        check("rst_tready", 64'(bus.s_tready), 64'd0);
        check("rst_wr_en", 64'(bus.fifo_wr_en), 64'd0);
        check("rst_din", 64'(bus.fifo_din), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_trunc_count", 64'(trunc_count), 64'd0);
        check("rst_grant_id", 64'(grant_id), 64'(NUM_SRC - 1));
        for (int s = 0; s < NUM_SRC; s++) src_q[s].delete();
        exp_q.delete();
        m_busy  = 0;
        m_src   = NUM_SRC - 1;
        m_beats = 0;
        m_pkts  = 0;
        m_trunc = 0;
        bus.s_tvalid  = '0;
        bus.s_tlast   = '0;
        bus.fifo_full = 1'b0;
        @(posedge wr_clk);
        @(negedge wr_clk);
        wr_rst = 1'b0;
        @(posedge wr_clk);
        #1;
    endtask

    // Monitor: compares handshake outputs each cycle and pops a word per FIFO write
    always @(negedge wr_clk) begin
        if (mon_en && !wr_rst) begin
            check("wr_en", 64'(bus.fifo_wr_en), 64'(exp_wr));
            check("tready", 64'(bus.s_tready), 64'(exp_ready));
            check("busy", 64'(busy), 64'(exp_busy));
            check("grant_id", 64'(grant_id), 64'(exp_gid));
            if (bus.fifo_wr_en) begin
                check("wr_while_full", 64'(bus.fifo_full), 64'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_write: din %0h with nothing expected at %0t", bus.fifo_din, $time);
                end else begin
                    mon_word = exp_q.pop_front();
                    check("fifo_din", 64'(bus.fifo_din), 64'(mon_word));
                end
                obs_cnt[bus.fifo_din[DATA_WIDTH +: ID_WIDTH]]++;
            end
        end
    end

    initial begin
        int budget;
        bus.s_tvalid  = '0;
        bus.s_tlast   = '0;
        bus.s_tdata   = '0;
        bus.fifo_full = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) obs_cnt[s] = 0;
        #2;
        do_reset();

        // Single 3-beat packet from source 1
        add_pkt(1, 3);
        drain();

        // Two contenders, source 0 queues a second packet
        do_reset();
        add_pkt(0, 2);
        add_pkt(2, 2);
        add_pkt(0, 2);
        drain();

        // FIFO full for 4 cycles after beat 2 of a 5-beat packet
        full_mode  = 2;
        stall_left = 4;
        add_pkt(2, 5);
        drain();
        full_mode = 0;
        check("stall_consumed", 64'(stall_left), 64'd0);

        // Overlong packet forced to terminate at the beat limit
        do_reset();
        add_pkt(3, 6);
        drain();
        check("trunc_pkt_count", 64'(pkt_count), 64'd2);
        check("trunc_trunc_count", 64'(trunc_count), 64'd1);

        // Reset while beat 2 of a packet is on the bus
        add_pkt(1, 4);
        budget = 50;
        while (!(m_busy && m_beats == 1) && budget > 0) begin
            run(1);
            budget--;
        end
        drive_and_model();
        #1;
        check("pre_rst_wr_en", 64'(bus.fifo_wr_en), 64'd1);
        do_reset();
        add_pkt(2, 1);
        add_pkt(1, 1);
        drain();

        // Three sources, single-beat packets, strict rotation
        for (int s = 0; s < NUM_SRC; s++) obs_cnt[s] = 0;
        for (int i = 0; i < 4; i++) begin
            add_pkt(0, 1);
            add_pkt(1, 1);
            add_pkt(2, 1);
        end
        drain();
        for (int s = 0; s < 3; s++) check("rr_grants", 64'(obs_cnt[s]), 64'd4);
        check("rr_idle_src", 64'(obs_cnt[3]), 64'd0);

        // Random traffic with valid gaps and random back-pressure
        gaps      = 1;
        full_mode = 1;
        repeat (8) begin
            repeat (5) add_pkt($urandom_range(NUM_SRC - 1), $urandom_range(1, 7));
            run($urandom_range(5, 20));
        end
        drain();
        gaps      = 0;
        full_mode = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
